// File: rtl/alu_bist_engine.sv
// Self-test driver for alu_unit: LFSR operands, cycling opcode, 16-bit MISR response compaction.
// One vector per cycle while busy; pass/done registered and held in DONE until start/abort/rst.
module alu_bist_engine #(
  parameter int          NUM_VECTORS  = 64,
  parameter logic [11:0] SEED         = 12'hACE,
  parameter logic [15:0] EXPECTED_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  alu_ans,
  output logic [5:0]  a,
  output logic [5:0]  b,
  output logic [2:0]  fxn,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [11:0] SEED_EFF = (SEED == 12'h000) ? 12'h001 : SEED;
  localparam logic [11:0] LAST_VEC = 12'(NUM_VECTORS - 1);

  state_t      state_q, state_d;
  logic [11:0] lfsr_q, lfsr_d;
  logic [11:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] misr_q, misr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    vec_cnt_d = vec_cnt_q;
    misr_d    = misr_q;
    // abort wins over start and over last-vector completion
    if (abort) begin
      state_d   = S_IDLE;
      lfsr_d    = 12'h000;
      vec_cnt_d = 12'h000;
      misr_d    = 16'h0000;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_RUN;
            lfsr_d    = SEED_EFF;
            vec_cnt_d = 12'h000;
            misr_d    = 16'h0000;
          end
        end
        S_RUN: begin
          misr_d    = {misr_q[14:0], misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3]}
                      ^ {10'b0, alu_ans};
          lfsr_d    = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};
          vec_cnt_d = vec_cnt_q + 12'h001;
          if (vec_cnt_q == LAST_VEC) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (misr_d == EXPECTED_SIG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 12'h000;
      vec_cnt_q <= 12'h000;
      misr_q    <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      vec_cnt_q <= vec_cnt_d;
      misr_q    <= misr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign a         = busy_q ? lfsr_q[11:6]     : 6'h00;
  assign b         = busy_q ? lfsr_q[5:0]      : 6'h00;
  assign fxn       = busy_q ? vec_cnt_q[2:0]   : 3'h0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_alu_bist_engine.sv
// Bench for alu_bist_engine: three instances (golden sig, wrong sig, zero seed) beside an alu model.
module tb_alu_bist_engine;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [5:0] alu_model(input logic [5:0] x, input logic [5:0] y,
                                           input logic [2:0] f);
    case (f)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ~x;
      3'd6: return {x[4:0], 1'b0};
      default: return y;
    endcase
  endfunction

  // Shift left, new LSB is the parity of the tapped bits.
  function automatic logic [11:0] lfsr_step(input logic [11:0] l);
    return {l[10:0], ^(l & 12'hE08)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] ans);
    return {m[14:0], ^(m & 16'hD008)} ^ {10'b0, ans};
  endfunction

  function automatic logic [15:0] gold_sig(input logic [11:0] seed, input int n);
    logic [11:0] l;
    logic [15:0] m;
    l = (seed == 12'h000) ? 12'h001 : seed;
    m = 16'h0000;
    for (int i = 0; i < n; i++) begin
      m = misr_step(m, alu_model(l[11:6], l[5:0], 3'(i % 8)));
      l = lfsr_step(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD   = gold_sig(12'hACE, 64);
  localparam logic [15:0] GOLD_Z = gold_sig(12'h000, 64);

  logic [5:0]  a_g, b_g, ans_g, a_x, b_x, ans_x, a_z, b_z, ans_z;
  logic [2:0]  fxn_g, fxn_x, fxn_z;
  logic        busy_g, done_g, pass_g, busy_x, done_x, pass_x, busy_z, done_z, pass_z;
  logic [15:0] sig_g, sig_x, sig_z;

  assign ans_g = alu_model(a_g, b_g, fxn_g);
  assign ans_x = alu_model(a_x, b_x, fxn_x);
  assign ans_z = alu_model(a_z, b_z, fxn_z);

  alu_bist_engine #(.NUM_VECTORS(64), .SEED(12'hACE), .EXPECTED_SIG(GOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .alu_ans(ans_g),
    .a(a_g), .b(b_g), .fxn(fxn_g), .busy(busy_g), .done(done_g), .pass(pass_g),
    .signature(sig_g));

  alu_bist_engine #(.NUM_VECTORS(64), .SEED(12'hACE), .EXPECTED_SIG(GOLD ^ 16'h0001)) dut_bad (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .alu_ans(ans_x),
    .a(a_x), .b(b_x), .fxn(fxn_x), .busy(busy_x), .done(done_x), .pass(pass_x),
    .signature(sig_x));

  alu_bist_engine #(.NUM_VECTORS(64), .SEED(12'h000), .EXPECTED_SIG(16'h0000)) dut_z (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .alu_ans(ans_z),
    .a(a_z), .b(b_z), .fxn(fxn_z), .busy(busy_z), .done(done_z), .pass(pass_z),
    .signature(sig_z));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    checks++;
    if ({a_g, b_g, fxn_g, busy_g, done_g, pass_g, sig_g} !== 34'd0)
      begin errors++; $display("FAIL reset_state: got %h required 0",
        {a_g, b_g, fxn_g, busy_g, done_g, pass_g, sig_g}); end
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy_g !== 1'b1 || sig_g === 16'h0000)
      begin errors++; $display("FAIL reset_prerun: busy=%b sig=%h required busy=1 sig!=0",
        busy_g, sig_g); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_g, b_g, fxn_g, busy_g, done_g, pass_g, sig_g, busy_z, sig_z} !== 51'd0)
      begin errors++; $display("FAIL reset_async: got %h required 0",
        {a_g, b_g, fxn_g, busy_g, done_g, pass_g, sig_g, busy_z, sig_z}); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy_g !== 1'b0 || done_g !== 1'b0 || sig_g !== 16'h0000)
      begin errors++; $display("FAIL reset_idle: busy=%b done=%b sig=%h required 0/0/0",
        busy_g, done_g, sig_g); end
  endtask

  task automatic test_first_vectors();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (a_g !== 6'b101011 || b_g !== 6'b001110 || fxn_g !== 3'd0)
      begin errors++; $display("FAIL vec1: a=%b b=%b fxn=%0d required 101011 001110 0",
        a_g, b_g, fxn_g); end
    checks++;
    if (a_z !== 6'b000000 || b_z !== 6'b000001)
      begin errors++; $display("FAIL seed0_vec1: a=%b b=%b required 000000 000001", a_z, b_z); end
    tick();
    checks++;
    if (a_g !== 6'b010110 || b_g !== 6'b011101 || fxn_g !== 3'd1)
      begin errors++; $display("FAIL vec2: a=%b b=%b fxn=%0d required 010110 011101 1",
        a_g, b_g, fxn_g); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Full 64-vector run; optionally pulses start mid-run, which must be ignored.
  task automatic run_full(input string name, input bit poke_start);
    logic [11:0] l;
    int          bad_vec;
    int          bad_ctl;
    l = 12'hACE;
    bad_vec = 0;
    bad_ctl = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      start = poke_start && (i == 20 || i == 40);
      if (busy_g !== 1'b1 || done_g !== 1'b0 || busy_z !== 1'b1) bad_ctl++;
      if ({a_g, b_g} !== l || fxn_g !== 3'(i % 8)) bad_vec++;
      l = lfsr_step(l);
      tick();
    end
    start = 1'b0;
    checks++;
    if (bad_ctl != 0)
      begin errors++; $display("FAIL %s_busy: %0d bad cycles required 0", name, bad_ctl); end
    checks++;
    if (bad_vec != 0)
      begin errors++; $display("FAIL %s_vectors: %0d bad vectors required 0", name, bad_vec); end
    checks++;
    if (done_g !== 1'b1 || busy_g !== 1'b0 || {a_g, b_g, fxn_g} !== 15'd0)
      begin errors++; $display("FAIL %s_done: done=%b busy=%b abf=%h required 1 0 0",
        name, done_g, busy_g, {a_g, b_g, fxn_g}); end
    checks++;
    if (sig_g !== GOLD || sig_x !== GOLD)
      begin errors++; $display("FAIL %s_sig: got %h/%h required %h", name, sig_g, sig_x, GOLD); end
    checks++;
    if (pass_g !== 1'b1 || pass_x !== 1'b0 || done_x !== 1'b1)
      begin errors++; $display("FAIL %s_pass: pass=%b bad_pass=%b required 1 0",
        name, pass_g, pass_x); end
    checks++;
    if (sig_z !== GOLD_Z || done_z !== 1'b1)
      begin errors++; $display("FAIL %s_seed0_sig: got %h required %h", name, sig_z, GOLD_Z); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (done_g !== 1'b1 || sig_g !== GOLD || pass_g !== 1'b1)
      begin errors++; $display("FAIL %s_hold: done=%b sig=%h pass=%b required 1 %h 1",
        name, done_g, sig_g, pass_g, GOLD); end
  endtask

  task automatic test_abort();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (done_g !== 1'b0 || pass_g !== 1'b0 || sig_g !== 16'h0000)
      begin errors++; $display("FAIL abort_done: done=%b pass=%b sig=%h required 0 0 0",
        done_g, pass_g, sig_g); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (fxn_g !== 3'd2 || busy_g !== 1'b1)
      begin errors++; $display("FAIL abort_pre: fxn=%0d busy=%b required 2 1", fxn_g, busy_g); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({a_g, b_g, fxn_g, busy_g, done_g, sig_g} !== 33'd0)
      begin errors++; $display("FAIL abort_run: got %h required 0",
        {a_g, b_g, fxn_g, busy_g, done_g, sig_g}); end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if (busy_g !== 1'b0 || done_g !== 1'b0 || sig_g !== 16'h0000)
      begin errors++; $display("FAIL abort_start: busy=%b done=%b sig=%h required 0 0 0",
        busy_g, done_g, sig_g); end
  endtask

  initial begin
    test_reset();
    test_first_vectors();
    run_full("full_run", 1'b0);
    run_full("restart_done", 1'b0);
    run_full("start_ignored", 1'b1);
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
